// File: rtl/traffic_fsm_if.sv
// Sensor inputs and light/servo outputs of the intersection sequencer.
// The sequencer takes the slave side and the sensor/servo side takes the master side.
interface traffic_fsm_if;
    logic       car_ns;
    logic       car_sn;
    logic       car_ew;
    logic       car_we;
    logic [5:0] tfst;
    logic [1:0] vel;
    logic [6:0] phase_cnt;

    modport master (
        output car_ns,
        output car_sn,
        output car_ew,
        output car_we,
        input  tfst,
        input  vel,
        input  phase_cnt
    );

    modport slave (
        input  car_ns,
        input  car_sn,
        input  car_ew,
        input  car_we,
        output tfst,
        output vel,
        output phase_cnt
    );
endinterface

// File: rtl/traffic_fsm.sv
// Three-group intersection phase sequencer with demand-adaptive greens and phase skipping.
// Drives the one-hot light state and the heavy-traffic servo speed request.
module traffic_fsm #(
    parameter int T_GREEN     = 100,
    parameter int T_MIN_GREEN = 40,
    parameter int T_YELLOW    = 30,
    parameter int T_HEAVY     = 20
) (
    input  logic         clk_10Hz,
    input  logic         rst_n,
    traffic_fsm_if.slave bus
);

    localparam int HW = $clog2(T_HEAVY + 1);

    localparam logic [6:0]    CNT_GREEN_LAST = 7'(T_GREEN - 1);
    localparam logic [6:0]    CNT_MIN_GREEN  = 7'(T_MIN_GREEN - 1);
    localparam logic [6:0]    CNT_YEL_LAST   = 7'(T_YELLOW - 1);
    localparam logic [HW-1:0] HEAVY_MAX      = HW'(T_HEAVY);

    // Encodings are decoded verbatim by the servo controller.
    typedef enum logic [5:0] {
        G_NS = 6'b100000,
        Y_NS = 6'b010000,
        G_EW = 6'b001000,
        Y_EW = 6'b000100,
        G_WE = 6'b000010,
        Y_WE = 6'b000001
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    tfst_q, tfst_d;
    logic [1:0]    vel_q, vel_d;
    logic [6:0]    phase_cnt_q, phase_cnt_d;
    logic [HW-1:0] ns_heavy_q, ns_heavy_d;
    logic [HW-1:0] sn_heavy_q, sn_heavy_d;
    logic [HW-1:0] oth_heavy_q, oth_heavy_d;

    logic dem_ns;
    logic dem_ew;
    logic dem_we;
    logic yel_done;

    assign dem_ns   = bus.car_ns | bus.car_sn;
    assign dem_ew   = bus.car_ew;
    assign dem_we   = bus.car_we;
    assign yel_done = (phase_cnt_q == CNT_YEL_LAST);

    // A green only gives way when someone else is waiting; otherwise it holds.
    function automatic logic green_exit(input logic own_dem, input logic other_dem,
                                        input logic [6:0] cnt);
        green_exit = other_dem &&
                     ((cnt == CNT_GREEN_LAST) || ((cnt >= CNT_MIN_GREEN) && !own_dem));
    endfunction

    // First group in rotation order with demand wins; no demand means plain rotation.
    function automatic state_e pick_green(input logic d1, input logic d2, input logic d3,
                                          input state_e g1, input state_e g2, input state_e g3);
        if (d1)
            pick_green = g1;
        else if (d2)
            pick_green = g2;
        else if (d3)
            pick_green = g3;
        else
            pick_green = g1;
    endfunction

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        sat_inc = (v == HEAVY_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            G_NS:    if (green_exit(dem_ns, dem_ew | dem_we, phase_cnt_q)) state_d = Y_NS;
            Y_NS:    if (yel_done) state_d = pick_green(dem_ew, dem_we, dem_ns, G_EW, G_WE, G_NS);
            G_EW:    if (green_exit(dem_ew, dem_ns | dem_we, phase_cnt_q)) state_d = Y_EW;
            Y_EW:    if (yel_done) state_d = pick_green(dem_we, dem_ns, dem_ew, G_WE, G_NS, G_EW);
            G_WE:    if (green_exit(dem_we, dem_ns | dem_ew, phase_cnt_q)) state_d = Y_WE;
            Y_WE:    if (yel_done) state_d = pick_green(dem_ns, dem_ew, dem_we, G_NS, G_EW, G_WE);
            default: state_d = G_NS;
        endcase
    end

    always_comb begin
        phase_cnt_d = phase_cnt_q;
        if (state_d != state_q)
            phase_cnt_d = '0;
        else if (phase_cnt_q != CNT_GREEN_LAST)
            phase_cnt_d = phase_cnt_q + 7'd1;
    end

    // Heavy counters measure sustained presence during the current green only.
    always_comb begin
        ns_heavy_d  = '0;
        sn_heavy_d  = '0;
        oth_heavy_d = '0;
        if (state_q == G_NS && bus.car_ns)
            ns_heavy_d = sat_inc(ns_heavy_q);
        if (state_q == G_NS && bus.car_sn)
            sn_heavy_d = sat_inc(sn_heavy_q);
        if ((state_q == G_EW && bus.car_ew) || (state_q == G_WE && bus.car_we))
            oth_heavy_d = sat_inc(oth_heavy_q);
    end

    // Outputs are decoded from next-state values so they align with the state edge.
    always_comb begin
        tfst_d = 6'(state_d);
        vel_d  = 2'b00;
        case (state_d)
            G_NS: begin
                vel_d[1] = (ns_heavy_d == HEAVY_MAX);
                vel_d[0] = (sn_heavy_d == HEAVY_MAX);
            end
            G_EW, G_WE: vel_d[0] = (oth_heavy_d == HEAVY_MAX);
            default:    vel_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_10Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= G_NS;
            tfst_q      <= 6'(G_NS);
            vel_q       <= 2'b00;
            phase_cnt_q <= '0;
            ns_heavy_q  <= '0;
            sn_heavy_q  <= '0;
            oth_heavy_q <= '0;
        end else begin
            state_q     <= state_d;
            tfst_q      <= tfst_d;
            vel_q       <= vel_d;
            phase_cnt_q <= phase_cnt_d;
            ns_heavy_q  <= ns_heavy_d;
            sn_heavy_q  <= sn_heavy_d;
            oth_heavy_q <= oth_heavy_d;
        end
    end

    assign bus.tfst      = tfst_q;
    assign bus.vel       = vel_q;
    assign bus.phase_cnt = phase_cnt_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench for traffic_fsm: hand-computed output-change events are queued by the
// stimulus and popped by a monitor whenever tfst or vel changes.
module tb_traffic_fsm;

    typedef struct {
        logic [5:0] tfst;
        logic [1:0] vel;
        int         cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    ev_t  exp_q[$];
    ev_t  mon_ev;
    logic [5:0] prev_tfst;
    logic [1:0] prev_vel;

    traffic_fsm_if bus_if();

    traffic_fsm dut (
        .clk_10Hz (clk),
        .rst_n    (rst_n),
        .bus      (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: after the k-th rising edge following reset release, cyc == k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input logic [5:0] t, input logic [1:0] v, input int c);
        ev_t e;
        e.tfst = t;
        e.vel  = v;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic set_cars(input logic ns, input logic sn, input logic ew, input logic we);
        bus_if.car_ns = ns;
        bus_if.car_sn = sn;
        bus_if.car_ew = ew;
        bus_if.car_we = we;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ns, input logic sn, input logic ew, input logic we);
        check("pending_events", exp_q.size(), 0);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("async_rst_tfst", bus_if.tfst, 6'b100000);
        check("async_rst_vel", bus_if.vel, 2'b00);
        check("async_rst_phase", bus_if.phase_cnt, 7'd0);
        set_cars(ns, sn, ew, we);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_tfst = bus_if.tfst;
            prev_vel  = bus_if.vel;
        end else if (bus_if.tfst !== prev_tfst || bus_if.vel !== prev_vel) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_change: actual tfst=%b vel=%b at cycle %0d, required no change",
                         bus_if.tfst, bus_if.vel, cyc);
            end else begin
                mon_ev = exp_q.pop_front();
                check("ev_tfst", bus_if.tfst, mon_ev.tfst);
                check("ev_vel", bus_if.vel, mon_ev.vel);
                check("ev_cycle", cyc, mon_ev.cyc);
                if (bus_if.tfst !== prev_tfst)
                    check("ev_phase_clear", bus_if.phase_cnt, 7'd0);
            end
            prev_tfst = bus_if.tfst;
            prev_vel  = bus_if.vel;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        set_cars(1'b0, 1'b0, 1'b0, 1'b0);
        #1;

        // No demand: G_NS holds, count saturates at 99.
        apply_reset(1'b0, 1'b0, 1'b0, 1'b0);
        wait_cyc(50);
        check("idle_phase_50", bus_if.phase_cnt, 7'd50);
        wait_cyc(120);
        check("idle_tfst", bus_if.tfst, 6'b100000);
        check("idle_vel", bus_if.vel, 2'b00);
        check("idle_phase_sat", bus_if.phase_cnt, 7'd99);

        // EW demand only: early release at 40, yellow 30, then EW heavy after 20.
        apply_reset(1'b0, 1'b0, 1'b1, 1'b0);
        push_ev(6'b010000, 2'b00, 40);
        push_ev(6'b001000, 2'b00, 70);
        push_ev(6'b001000, 2'b01, 90);
        wait_cyc(200);
        check("ew_hold_tfst", bus_if.tfst, 6'b001000);
        check("ew_hold_vel", bus_if.vel, 2'b01);
        check("ew_hold_phase", bus_if.phase_cnt, 7'd99);

        // Same start, reset pulsed at phase_cnt 15 of G_EW.
        apply_reset(1'b0, 1'b0, 1'b1, 1'b0);
        push_ev(6'b010000, 2'b00, 40);
        push_ev(6'b001000, 2'b00, 70);
        wait_cyc(85);
        check("pre_pulse_tfst", bus_if.tfst, 6'b001000);
        check("pre_pulse_phase", bus_if.phase_cnt, 7'd15);

        // NS and EW both busy: full 100-cycle greens, WE skipped back to NS.
        apply_reset(1'b1, 1'b0, 1'b1, 1'b0);
        push_ev(6'b100000, 2'b10, 20);
        push_ev(6'b010000, 2'b00, 100);
        push_ev(6'b001000, 2'b00, 130);
        push_ev(6'b001000, 2'b01, 150);
        push_ev(6'b000100, 2'b00, 230);
        push_ev(6'b100000, 2'b00, 260);
        push_ev(6'b100000, 2'b10, 280);
        wait_cyc(300);
        check("busy_vel_ns", bus_if.vel, 2'b10);

        // WE only: EW skipped; later NS demand releases WE early.
        apply_reset(1'b0, 1'b0, 1'b0, 1'b1);
        push_ev(6'b010000, 2'b00, 40);
        push_ev(6'b000010, 2'b00, 70);
        push_ev(6'b000010, 2'b01, 90);
        wait_cyc(150);
        set_cars(1'b1, 1'b0, 1'b0, 1'b0);
        push_ev(6'b000001, 2'b00, 151);
        push_ev(6'b100000, 2'b00, 181);
        push_ev(6'b100000, 2'b10, 201);
        wait_cyc(220);

        // Demand changes mid-yellow: only the value on the last yellow cycle counts.
        apply_reset(1'b0, 1'b0, 1'b1, 1'b0);
        push_ev(6'b010000, 2'b00, 40);
        wait_cyc(60);
        set_cars(1'b0, 1'b0, 1'b0, 1'b1);
        push_ev(6'b000010, 2'b00, 70);
        push_ev(6'b000010, 2'b01, 90);
        wait_cyc(110);
        check("final_tfst", bus_if.tfst, 6'b000010);
        check("pending_events", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
